reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised multi-read-port integer register file with write-back bypass and a per-register pending-write scoreboard. It is the next-generation register file for the pipelined core. Issue logic marks a destination register as pending. Write-back clears the mark and updates the array. Each read port reports busy so decode can stall on read-after-write hazards.

Parameters:
- reg_addr_width, 5, register index width
- reg_data_width, 32, register data width
- reg_depth, 32, number of registers; must be ≤ 2**reg_addr_width
- num_rd, 2, number of read ports (1..4)
- zero_reg, 1, 1 = register 0 is hard-wired to zero; 0 = register 0 is an ordinary register

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- r_addr  in  num_rd*reg_addr_width  read addresses; port k is bits [k*AW +: AW]
- r_data  out  num_rd*reg_data_width  read data, port k packed the same way
- r_busy  out  num_rd  port k source register is pending and not bypassed this cycle
- write_back_en  in  1  write-back strobe
- wr_addr  in  reg_addr_width  write-back address
- wr_data  in  reg_data_width  write-back data
- iss_en  in  1  issue request: mark iss_addr as pending
- iss_addr  in  reg_addr_width  issue destination
- iss_stall  out  1  issue refused this cycle
- pend_cnt  out  reg_addr_width+1  number of registers currently pending

Behaviour:
- Single clock domain. Reset is synchronous and active-high on ports clk and rst.
- Reset:
  - On a rising clk with rst=1, all array entries go to 0, all pending bits go to 0, and pend_cnt goes to 0.
  - rst dominates write_back_en and iss_en in the same cycle.
- Write:
  - On a rising clk with write_back_en=1, array[wr_addr] <= wr_data. Latency is one edge.
  - The write is ignored if wr_addr ≥ reg_depth, or if zero_reg=1 and wr_addr=0.
- Read (combinational, every port independent):
  - Out-of-range address, or address 0 with zero_reg=1 → r_data=0 and r_busy=0.
  - Bypass hit (write_back_en=1, wr_addr=r_addr[k], and the write is legal) → r_data[k]=wr_data and r_busy[k]=0.
  - Otherwise → r_data[k]=array[r_addr[k]] and r_busy[k]=pending[r_addr[k]].
- Scoreboard (one pending bit per register):
  - Write-back of a legal address clears pending[wr_addr] at the edge. This applies even if the bit was already 0; no error is flagged.
  - iss_stall = iss_en and pending[iss_addr] and not (write_back_en and wr_addr=iss_addr).
  - Issue with iss_en=1, iss_stall=0, and a legal iss_addr sets pending[iss_addr] at the edge.
  - Issue to register 0 with zero_reg=1, or to an out-of-range address: no stall, no pending bit set.
  - Simultaneous write-back and issue to the same register: the array is written, and pending ends at 1 (set wins over clear).
  - A stalled issue changes no state. The requester must hold iss_en and iss_addr until iss_stall=0.
- pend_cnt:
  - Registered population count of the pending bits; always equals the number of set bits after each edge.
  - Per cycle it changes by −1, 0 or +1. Net change is 0 when a clear and a set hit the same register, or hit different registers in the same cycle.
- Undriven array entries are never visible, because reset clears all state.

Test Plan:
1. Reset, then write x3=5 and x4=7; read ports 0/1 at 3/4 → r_data = 5/7, r_busy = 00, pend_cnt = 0.
2. Write to x0 = 0xDEADBEEF with zero_reg=1 → reading 0 returns 0. Repeat with zero_reg=0 → reading 0 returns 0xDEADBEEF.
3. Issue x5, then read x5 → r_busy=1 and pend_cnt=1. Next cycle, write-back x5=0x1234 while reading x5 → same-cycle r_data=0x1234 and r_busy=0. After the edge, pend_cnt=0.
4. Issue x6, then issue x6 again → iss_stall=1 and pend_cnt stays 1. Then issue x6 together with write-back x6=9 → iss_stall=0, array x6=9, pending[x6] stays 1, pend_cnt=1.
5. Issue x7, x8 and x9 on consecutive cycles → pend_cnt = 1, 2, 3. Assert rst during a cycle with write-back x7=1 and issue x10 → after the edge everything is 0 and x7 reads 0.
6. Randomised issue/write-back mix for 10k cycles against a reference model → r_data, r_busy, iss_stall and pend_cnt always match, and pend_cnt never exceeds reg_depth.

Source files
------------

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Multi-read-port integer register file with a write-back bypass and a
// per-register pending-write scoreboard for the pipelined core.
//
//   * Issue logic marks a destination register as pending (iss_en/iss_addr).
//     A request to a register that is already pending is refused (iss_stall)
//     unless the same register is being written back in that cycle.
//   * Write-back (write_back_en/wr_addr/wr_data) updates the array and clears
//     the pending mark at the same edge.
//   * Every read port is combinational. It forwards same-cycle write-back
//     data and reports r_busy while its source register is still pending,
//     so decode can stall on read-after-write hazards.
//   * pend_cnt is a registered count of the pending marks.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   r_addr         in   num_rd read addresses, port k = [k*AW +: AW]
//   r_data         out  num_rd read data words, port k = [k*DW +: DW]
//   r_busy         out  per-port: source is pending and not bypassed
//   write_back_en  in   write-back strobe
//   wr_addr        in   write-back register index
//   wr_data        in   write-back data
//   iss_en         in   issue request (mark iss_addr pending)
//   iss_addr       in   issue destination register index
//   iss_stall      out  issue refused this cycle
//   pend_cnt       out  number of registers currently pending
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32,
    parameter int reg_depth      = 32,
    parameter int num_rd         = 2,
    parameter int zero_reg       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [num_rd*reg_addr_width-1:0]   r_addr,
    output logic [num_rd*reg_data_width-1:0]   r_data,
    output logic [num_rd-1:0]                  r_busy,
    input  logic                               write_back_en,
    input  logic [reg_addr_width-1:0]          wr_addr,
    input  logic [reg_data_width-1:0]          wr_data,
    input  logic                               iss_en,
    input  logic [reg_addr_width-1:0]          iss_addr,
    output logic                               iss_stall,
    output logic [reg_addr_width:0]            pend_cnt
);

    localparam int AW = reg_addr_width;
    localparam int DW = reg_data_width;

    // Depth held one bit wider than an address so that a depth of exactly
    // 2**AW is representable and every address compares below it.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(reg_depth);

    // An address names a real, writable register: inside the array and not
    // the hard-wired zero register.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < DEPTH_W);
        is_zero  = (zero_reg != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DW-1:0]        mem_q [reg_depth];
    logic [DW-1:0]        mem_d [reg_depth];
    logic [reg_depth-1:0] pend_q;
    logic [reg_depth-1:0] pend_d;
    logic [AW:0]          pend_cnt_q;
    logic [AW:0]          pend_cnt_d;

    // -----------------------------------------------------------------------
    // Write-back and issue qualification
    // -----------------------------------------------------------------------
    logic wr_legal;
    logic iss_legal;
    logic iss_pend;
    logic iss_set;

    assign wr_legal  = write_back_en && addr_legal(wr_addr);
    assign iss_legal = addr_legal(iss_addr);

    // Pending bit of the issue destination. Out-of-range addresses match no
    // register and read as not pending, so they never stall.
    always_comb begin
        iss_pend = 1'b0;
        for (int i = 0; i < reg_depth; i++) begin
            if (iss_addr == AW'(i)) begin
                iss_pend = pend_q[i];
            end
        end
    end

    // A write-back to the same register in this cycle retires the older
    // producer, so the new issue may proceed instead of stalling.
    assign iss_stall = iss_en && iss_pend && !(write_back_en && (wr_addr == iss_addr));
    assign iss_set   = iss_en && !iss_stall && iss_legal;

    // -----------------------------------------------------------------------
    // Per-register next state
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < reg_depth; gi++) begin : g_reg
        logic wr_hit;
        logic iss_hit;

        assign wr_hit  = wr_legal && (wr_addr == AW'(gi));
        assign iss_hit = iss_set && (iss_addr == AW'(gi));

        assign mem_d[gi] = wr_hit ? wr_data : mem_q[gi];

        // Set has priority over clear: a write-back and a new issue to the
        // same register leave it pending for the newer producer.
        assign pend_d[gi] = iss_hit ? 1'b1 : (wr_hit ? 1'b0 : pend_q[gi]);
    end

    // Count is taken from the next-state vector so the registered value
    // always equals the population of pend_q after each edge.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < reg_depth; i++) begin
            pend_cnt_d = pend_cnt_d + (AW + 1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < reg_depth; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < reg_depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    for (genvar gk = 0; gk < num_rd; gk++) begin : g_rd
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rd_data;
        logic          rd_busy;

        assign rd_addr = r_addr[gk*AW +: AW];

        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (addr_legal(rd_addr)) begin
                if (wr_legal && (wr_addr == rd_addr)) begin
                    // Forward the value being written back; the producer
                    // has completed, so the register is no longer busy.
                    rd_data = wr_data;
                end else begin
                    for (int i = 0; i < reg_depth; i++) begin
                        if (rd_addr == AW'(i)) begin
                            rd_data = mem_q[i];
                            rd_busy = pend_q[i];
                        end
                    end
                end
            end
        end

        assign r_data[gk*DW +: DW] = rd_data;
        assign r_busy[gk]          = rd_busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Two instances share one stimulus stream:
//   dut_a : 32 registers, register 0 hard-wired to zero
//   dut_b : 24 registers (indices 24..31 out of range), register 0 ordinary
// A reference model of the register file behaviour predicts every output of
// both instances on every cycle; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ra0, ra1;
    logic [NR*AW-1:0] r_addr;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] ia;

    logic [NR*DW-1:0] r_data_a, r_data_b;
    logic [NR-1:0]    r_busy_a, r_busy_b;
    logic             stall_a, stall_b;
    logic [AW:0]      cnt_a, cnt_b;

    assign r_addr = {ra1, ra0};

    reg_file_sb #(
        .reg_addr_width(AW), .reg_data_width(DW), .reg_depth(32),
        .num_rd(NR), .zero_reg(1)
    ) dut_a (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data_a), .r_busy(r_busy_a),
        .write_back_en(we), .wr_addr(wa), .wr_data(wd),
        .iss_en(ie), .iss_addr(ia), .iss_stall(stall_a), .pend_cnt(cnt_a)
    );

    reg_file_sb #(
        .reg_addr_width(AW), .reg_data_width(DW), .reg_depth(24),
        .num_rd(NR), .zero_reg(0)
    ) dut_b (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
        .write_back_en(we), .wr_addr(wa), .wr_data(wd),
        .iss_en(ie), .iss_addr(ia), .iss_stall(stall_b), .pend_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: architectural register values and outstanding writes
    // -----------------------------------------------------------------------
    bit [31:0] m_mem  [2][32];
    bit        m_pend [2][32];

    function automatic int m_depth(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit m_legal(input int k, input int a);
        if (a >= m_depth(k)) return 1'b0;
        if (k == 0 && a == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count(input int k);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[k][i]);
        return c;
    endfunction

    function automatic bit m_stall(input int k);
        return ie && m_pend[k][int'(ia)] && !(we && wa == ia);
    endfunction

    // Outputs are checked in the middle of the cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [NR*DW-1:0] act_d;
                logic [NR-1:0]    act_b;
                logic             act_s;
                logic [AW:0]      act_c;
                act_d = (k == 0) ? r_data_a : r_data_b;
                act_b = (k == 0) ? r_busy_a : r_busy_b;
                act_s = (k == 0) ? stall_a  : stall_b;
                act_c = (k == 0) ? cnt_a    : cnt_b;
                for (int p = 0; p < NR; p++) begin
                    int        ra;
                    bit [31:0] ed;
                    bit        eb;
                    ra = (p == 0) ? int'(ra0) : int'(ra1);
                    if (!m_legal(k, ra)) begin
                        ed = 0; eb = 0;
                    end else if (we && int'(wa) == ra) begin
                        ed = wd; eb = 0;
                    end else begin
                        ed = m_mem[k][ra]; eb = m_pend[k][ra];
                    end
                    check($sformatf("model_rdata i%0d p%0d", k, p), 64'(act_d[p*DW +: DW]), 64'(ed));
                    check($sformatf("model_rbusy i%0d p%0d", k, p), 64'(act_b[p]), 64'(eb));
                end
                check($sformatf("model_stall i%0d", k), 64'(act_s), 64'(m_stall(k)));
                check($sformatf("model_cnt i%0d", k), 64'(act_c), 64'(m_count(k)));
                check($sformatf("cnt_le_depth i%0d", k), 64'(int'(act_c) <= m_depth(k)), 64'(1));
            end
        end
    end

    // Model state advances on the same edge as the DUT; inputs are still
    // stable here because the stimulus changes them 1 time unit later.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = 0;
                    m_pend[k][i] = 0;
                end
            end else begin
                bit s;
                s = m_stall(k);
                if (we && m_legal(k, int'(wa))) begin
                    m_mem[k][int'(wa)]  = wd;
                    m_pend[k][int'(wa)] = 0;
                end
                if (ie && !s && m_legal(k, int'(ia))) m_pend[k][int'(ia)] = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed steps with hand-computed expectations, then a random mix
    // -----------------------------------------------------------------------
    initial begin
        rst = 1; we = 0; wa = 0; wd = 0; ie = 0; ia = 0; ra0 = 0; ra1 = 0;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 0;
        ra0 = 3;
        @(negedge clk);
        check("reset_cnt", 64'(cnt_a), 64'd0);
        check("reset_x3", 64'(r_data_a[31:0]), 64'd0);

        // Step 1: write x3=5, x4=7, read back on both ports
        tick();
        we = 1; wa = 3; wd = 5;
        @(negedge clk);
        check("bypass_x3", 64'(r_data_a[31:0]), 64'd5);
        tick();
        wa = 4; wd = 7;
        tick();
        we = 0; ra0 = 3; ra1 = 4;
        @(negedge clk);
        check("read_x3", 64'(r_data_a[31:0]), 64'd5);
        check("read_x4", 64'(r_data_a[63:32]), 64'd7);
        check("busy_00", 64'(r_busy_a), 64'd0);
        check("cnt_0", 64'(cnt_a), 64'd0);

        // Step 2: x0 behaviour with and without the hard-wired zero
        tick();
        we = 1; wa = 0; wd = 32'hDEADBEEF; ra0 = 0;
        @(negedge clk);
        check("x0_byp_zero", 64'(r_data_a[31:0]), 64'd0);
        check("x0_byp_plain", 64'(r_data_b[31:0]), 64'hDEADBEEF);
        tick();
        we = 0;
        @(negedge clk);
        check("x0_zero", 64'(r_data_a[31:0]), 64'd0);
        check("x0_plain", 64'(r_data_b[31:0]), 64'hDEADBEEF);
        tick();
        we = 1; wa = 25; wd = 32'hA5A5; ra1 = 25;
        tick();
        we = 0;
        @(negedge clk);
        check("x25_in_range", 64'(r_data_a[63:32]), 64'hA5A5);
        check("x25_out_range", 64'(r_data_b[63:32]), 64'd0);

        // Step 3: issue x5, then retire it with a bypassed write-back
        tick();
        ie = 1; ia = 5; ra0 = 5; ra1 = 3;
        @(negedge clk);
        check("iss5_stall", 64'(stall_a), 64'd0);
        check("iss5_busy_before", 64'(r_busy_a[0]), 64'd0);
        tick();
        ie = 0;
        @(negedge clk);
        check("x5_busy", 64'(r_busy_a[0]), 64'd1);
        check("x5_cnt", 64'(cnt_a), 64'd1);
        tick();
        we = 1; wa = 5; wd = 32'h1234;
        @(negedge clk);
        check("x5_byp_data", 64'(r_data_a[31:0]), 64'h1234);
        check("x5_byp_busy", 64'(r_busy_a[0]), 64'd0);
        tick();
        we = 0;
        @(negedge clk);
        check("x5_cnt_after", 64'(cnt_a), 64'd0);
        check("x5_data_after", 64'(r_data_a[31:0]), 64'h1234);

        // Step 4: stall on a pending register, then issue alongside write-back
        tick();
        ie = 1; ia = 6; ra0 = 6;
        @(negedge clk);
        check("iss6_first", 64'(stall_a), 64'd0);
        tick();
        @(negedge clk);
        check("iss6_stall", 64'(stall_a), 64'd1);
        check("iss6_cnt", 64'(cnt_a), 64'd1);
        tick();
        we = 1; wa = 6; wd = 9;
        @(negedge clk);
        check("iss6_wb_stall", 64'(stall_a), 64'd0);
        check("iss6_wb_cnt", 64'(cnt_a), 64'd1);
        tick();
        ie = 0; we = 0;
        @(negedge clk);
        check("x6_data", 64'(r_data_a[31:0]), 64'd9);
        check("x6_still_busy", 64'(r_busy_a[0]), 64'd1);
        check("x6_cnt", 64'(cnt_a), 64'd1);
        tick();
        we = 1; wa = 6; wd = 9;
        tick();
        we = 0;
        @(negedge clk);
        check("x6_cleared", 64'(cnt_a), 64'd0);

        // Step 5: fill three, then reset over a write-back and an issue
        tick();
        ie = 1; ia = 7;
        tick();
        ia = 8;
        @(negedge clk);
        check("fill_cnt1", 64'(cnt_a), 64'd1);
        tick();
        ia = 9;
        @(negedge clk);
        check("fill_cnt2", 64'(cnt_a), 64'd2);
        tick();
        rst = 1; ia = 10; we = 1; wa = 7; wd = 1;
        @(negedge clk);
        check("fill_cnt3", 64'(cnt_a), 64'd3);
        tick();
        rst = 0; ie = 0; we = 0; ra0 = 7; ra1 = 3;
        @(negedge clk);
        check("rst_cnt", 64'(cnt_a), 64'd0);
        check("rst_x7", 64'(r_data_a[31:0]), 64'd0);
        check("rst_x7_busy", 64'(r_busy_a[0]), 64'd0);
        check("rst_x3", 64'(r_data_a[63:32]), 64'd0);

        // Step 6: random issue / write-back mix checked by the model
        for (int n = 0; n < 10000; n++) begin
            tick();
            rst = ($urandom_range(0, 999) == 0);
            we  = $urandom_range(0, 1);
            ie  = $urandom_range(0, 1);
            wa  = AW'($urandom_range(0, 31));
            ia  = AW'($urandom_range(0, 31));
            ra0 = AW'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            wd  = $urandom;
        end
        tick();
        rst = 0; we = 0; ie = 0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
